// File: rtl/pit_data_responder.sv
// pit_data_responder: PIT-side responder for the FIB->PIT data handshake; define PIT_ENTRY_TIMEOUT_EN to age out stale entries
module pit_data_responder #(
  parameter int ENTRIES        = 8,
  parameter int DATA_BYTES     = 1024,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        interest_valid,
  input  logic [63:0] interest_prefix,
  input  logic [5:0]  interest_len,
  output logic        interest_ready,
  input  logic        prefix_ready,
  input  logic [63:0] fib_prefix,
  input  logic [5:0]  fib_len,
  input  logic [7:0]  data_in,
  output logic        rejected,
  output logic        start_send,
  output logic [7:0]  data_out,
  output logic        data_out_valid,
  output logic        data_last,
  output logic        busy,
  output logic        table_full
);
  localparam int IW = $clog2(ENTRIES);
  localparam int CW = $clog2(DATA_BYTES) + 1;
  localparam logic [2:0] IDLE = 3'd0, SCAN = 3'd1, RESPOND = 3'd2, RECEIVE = 3'd3, RELEASE = 3'd4;
  logic [2:0] state;
  logic [ENTRIES-1:0] valid, valid_nxt, match, expire;
  logic [63:0] prefix [ENTRIES];
  logic [5:0] len [ENTRIES];
  logic [63:0] q_prefix;
  logic [5:0] q_len;
  logic [IW-1:0] idx, hit_idx, free_idx;
  logic [CW-1:0] cnt;
  logic accept, insert, hit;

  if (ENTRIES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("pit_data_responder: ENTRIES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  assign busy = state != IDLE;
  assign interest_ready = !table_full && state != RELEASE;
  assign accept = interest_valid && interest_ready;
  assign insert = accept && !(|match);
  assign hit = valid[idx] && !expire[idx] && prefix[idx] == q_prefix && len[idx] == q_len;

  // Duplicate detection for aggregation and lowest free slot for fresh inserts
  always_comb begin
    match = '0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      match[i] = valid[i] && prefix[i] == interest_prefix && len[i] == interest_len;
      if (!valid[i]) free_idx = IW'(i);
    end
  end

`ifdef PIT_ENTRY_TIMEOUT_EN
  localparam int AW = $clog2(TIMEOUT_CYCLES + 1);
  logic [AW-1:0] age [ENTRIES];
  logic xfer;
  assign xfer = state == RESPOND || state == RECEIVE || state == RELEASE;
  // A slot dies at its lifetime unless it is being served or refreshed this cycle
  always_comb begin
    expire = '0;
    for (int i = 0; i < ENTRIES; i++)
      expire[i] = valid[i] && age[i] == AW'(TIMEOUT_CYCLES) && !(xfer && hit_idx == IW'(i)) && !(accept && match[i]);
  end
  // Ages restart on insert or aggregation and saturate at the lifetime
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < ENTRIES; i++) age[i] <= '0;
    else for (int i = 0; i < ENTRIES; i++)
      if ((insert && free_idx == IW'(i)) || (accept && match[i])) age[i] <= '0;
      else if (valid[i] && age[i] != AW'(TIMEOUT_CYCLES)) age[i] <= age[i] + AW'(1);
`else
  assign expire = '0;
`endif

  // Next valid map: expiries, release of the served slot, then fresh insert
  always_comb begin
    valid_nxt = valid & ~expire;
    if (state == RELEASE) valid_nxt[hit_idx] = 1'b0;
    if (insert) valid_nxt[free_idx] = 1'b1;
  end

  // Entry payload; only the valid bits need a reset
  always_ff @(posedge clk)
    if (insert) begin
      prefix[free_idx] <= interest_prefix;
      len[free_idx] <= interest_len;
    end

  // Query/transfer state machine with registered handshake and stream outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      valid <= '0;
      table_full <= 1'b0;
      rejected <= 1'b0;
      start_send <= 1'b0;
      data_out <= '0;
      data_out_valid <= 1'b0;
      data_last <= 1'b0;
      idx <= '0;
      hit_idx <= '0;
      cnt <= '0;
      q_prefix <= '0;
      q_len <= '0;
    end else begin
      valid <= valid_nxt;
      table_full <= &valid_nxt;
      rejected <= 1'b0;
      start_send <= 1'b0;
      data_out_valid <= 1'b0;
      data_last <= 1'b0;
      case (state)
        IDLE: if (prefix_ready) begin
          q_prefix <= fib_prefix;
          q_len <= fib_len;
          idx <= '0;
          state <= SCAN;
        end
        SCAN: if (hit) begin
          hit_idx <= idx;
          start_send <= 1'b1;
          state <= RESPOND;
        end else if (idx == IW'(ENTRIES - 1)) begin
          rejected <= 1'b1;
          state <= IDLE;
        end else idx <= idx + IW'(1);
        RESPOND: begin
          cnt <= '0;
          state <= RECEIVE;
        end
        RECEIVE: begin
          data_out <= data_in;
          data_out_valid <= 1'b1;
          data_last <= cnt == CW'(DATA_BYTES - 1);
          if (cnt == CW'(DATA_BYTES - 1)) state <= RELEASE;
          else cnt <= cnt + CW'(1);
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pit_data_responder.sv
// tb_pit_data_responder: directed and randomized checks of pit_data_responder against a slot-table model
module tb_pit_data_responder;
  localparam int ENTRIES = 8;
  localparam int DATA_BYTES = 1024;
  logic clk = 1'b0, rst = 1'b1;
  logic interest_valid = 1'b0;
  logic [63:0] interest_prefix = '0;
  logic [5:0] interest_len = '0;
  logic interest_ready;
  logic prefix_ready = 1'b0;
  logic [63:0] fib_prefix = '0;
  logic [5:0] fib_len = '0;
  logic [7:0] data_in = '0;
  logic rejected, start_send, data_out_valid, data_last, busy, table_full;
  logic [7:0] data_out;
  int vectors = 0, miscompares = 0;
  bit m_valid [ENTRIES];
  logic [63:0] m_prefix [ENTRIES];
  logic [5:0] m_len [ENTRIES];

  always #5 clk = ~clk;

  pit_data_responder #(.ENTRIES(ENTRIES), .DATA_BYTES(DATA_BYTES), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst),
    .interest_valid(interest_valid), .interest_prefix(interest_prefix), .interest_len(interest_len),
    .interest_ready(interest_ready),
    .prefix_ready(prefix_ready), .fib_prefix(fib_prefix), .fib_len(fib_len),
    .data_in(data_in),
    .rejected(rejected), .start_send(start_send),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_last(data_last),
    .busy(busy), .table_full(table_full)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [63:0] got, logic [63:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int m_lookup(logic [63:0] p, logic [5:0] l);
    for (int i = 0; i < ENTRIES; i++) if (m_valid[i] && m_prefix[i] == p && m_len[i] == l) return i;
    return -1;
  endfunction

  function automatic bit m_full();
    foreach (m_valid[i]) if (!m_valid[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void m_insert(logic [63:0] p, logic [5:0] l);
    if (m_lookup(p, l) >= 0) return;
    for (int i = 0; i < ENTRIES; i++) if (!m_valid[i]) begin
      m_valid[i] = 1'b1;
      m_prefix[i] = p;
      m_len[i] = l;
      return;
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    interest_valid = 1'b0;
    prefix_ready = 1'b0;
    data_in = '0;
    @(negedge clk);
    rst = 1'b0;
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  task automatic insert(logic [63:0] p, logic [5:0] l);
    bit want_ready = !m_full();
    check("ins_ready", interest_ready, want_ready);
    interest_valid = 1'b1;
    interest_prefix = p;
    interest_len = l;
    @(negedge clk);
    interest_valid = 1'b0;
    if (want_ready) m_insert(p, l);
    check("table_full", table_full, m_full());
  endtask

  task automatic query(logic [63:0] p, logic [5:0] l, bit ins, output int when, output int k);
    prefix_ready = 1'b1;
    fib_prefix = p;
    fib_len = l;
    if (ins) begin
      interest_valid = 1'b1;
      interest_prefix = p;
      interest_len = l;
      if (!m_full()) m_insert(p, l);
    end
    k = m_lookup(p, l);
    @(negedge clk);
    prefix_ready = 1'b0;
    interest_valid = 1'b0;
    fib_prefix = {$urandom(), $urandom()};
    fib_len = 6'($urandom());
    when = -1;
    for (int c = 1; c <= ENTRIES + 4 && when < 0; c++) begin
      if (c == 1) check("busy_scan", busy, 1);
      if (start_send || rejected) begin
        when = c;
        check("start_send", start_send, k >= 0);
        check("rejected", rejected, k < 0);
        check("resp_cycle", c, k >= 0 ? k + 2 : ENTRIES + 1);
      end else @(negedge clk);
    end
    if (when < 0) check("resp_timeout", 0, 1);
  endtask

  task automatic stream(int abort_at, bit rnd, int k);
    logic [7:0] q [$];
    logic [7:0] b;
    for (int i = 0; i <= DATA_BYTES; i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_outs", {rejected, start_send, data_out_valid, data_last, busy, table_full, data_out}, 0);
        check("abort_ready", interest_ready, 1);
        foreach (m_valid[j]) m_valid[j] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (i == 0) check("first_recv", {start_send, data_out_valid}, 0);
      else begin
        b = q.pop_front();
        check("beat", {data_out_valid, data_last, data_out}, {1'b1, i == DATA_BYTES, b});
      end
      if (i < DATA_BYTES) begin
        b = rnd ? 8'($urandom()) : 8'(i);
        data_in = b;
        q.push_back(b);
      end
    end
    check("busy_release", busy, 1);
    @(negedge clk);
    check("idle_after", {busy, data_out_valid, data_last}, 0);
    if (k >= 0) m_valid[k] = 1'b0;
  endtask

  task automatic transact(logic [63:0] p, logic [5:0] l, bit ins, int abort_at, bit rnd);
    int when, k;
    query(p, l, ins, when, k);
    if (when > 0 && start_send) stream(abort_at, rnd, k);
    else if (when > 0) begin
      @(negedge clk);
      check("reject_pulse", {rejected, start_send, busy}, 0);
    end else do_reset();
  endtask

  initial begin
    logic [63:0] p;
    logic [63:0] fill [ENTRIES + 1];
    logic [63:0] pp [3];
    int n, j;
    @(negedge clk);
    check("reset_outs", {rejected, start_send, data_out_valid, data_last, busy, table_full, data_out}, 0);
    check("reset_ready", interest_ready, 1);
    rst = 1'b0;
    // hit on slot 0 of a 3-entry table, counting byte pattern
    insert(64'hA5A5_0000_0000_0001, 6'd16);
    insert({$urandom(), $urandom()}, 6'd33);
    insert({$urandom(), $urandom()}, 6'd40);
    transact(64'hA5A5_0000_0000_0001, 6'd16, 1'b0, -1, 1'b0);
    transact(64'hA5A5_0000_0000_0001, 6'd16, 1'b0, -1, 1'b0);
    // miss on an empty table
    do_reset();
    transact(64'h1234, 6'd8, 1'b0, -1, 1'b0);
    // fill, aggregate, overflow
    do_reset();
    for (int i = 0; i <= ENTRIES; i++) fill[i] = {32'(i + 1), $urandom()};
    for (int i = 0; i < ENTRIES - 1; i++) insert(fill[i], 6'd12);
    insert(fill[2], 6'd12);
    insert(fill[ENTRIES - 1], 6'd12);
    check("full_ready", interest_ready, 0);
    insert(fill[ENTRIES], 6'd12);
    transact(fill[ENTRIES], 6'd12, 1'b0, -1, 1'b1);
    transact(fill[ENTRIES - 1], 6'd12, 1'b0, -1, 1'b1);
    check("full_after_release", table_full, 0);
    // length must match exactly
    do_reset();
    p = {$urandom(), $urandom()};
    insert(p, 6'd20);
    transact(p, 6'd19, 1'b0, -1, 1'b1);
    transact(p, 6'd20, 1'b0, -1, 1'b1);
    // insert and query in the same IDLE cycle
    do_reset();
    insert({$urandom(), $urandom()}, 6'd1);
    insert({$urandom(), $urandom()}, 6'd2);
    transact(p, 6'd7, 1'b1, -1, 1'b1);
    // reset during RECEIVE
    do_reset();
    insert(p, 6'd9);
    transact(p, 6'd9, 1'b0, 500, 1'b1);
    transact(p, 6'd9, 1'b0, -1, 1'b1);
    // randomized tables and queries
    for (int r = 0; r < 4; r++) begin
      do_reset();
      foreach (pp[i]) pp[i] = {$urandom(), $urandom()};
      n = $urandom_range(1, ENTRIES);
      for (int i = 0; i < n; i++) begin
        j = $urandom_range(0, 5);
        insert(pp[j % 3], 6'(j + 10));
      end
      j = $urandom_range(0, 5);
      transact(pp[j % 3], 6'(j + 10), 1'b0, -1, 1'b1);
    end
`ifdef PIT_ENTRY_TIMEOUT_EN
    // entry expires before a late query
    do_reset();
    insert(p, 6'd5);
    repeat (149) @(negedge clk);
    m_valid[0] = 1'b0;
    transact(p, 6'd5, 1'b0, -1, 1'b1);
    // entry served in time survives its transfer
    do_reset();
    insert(p, 6'd5);
    repeat (48) @(negedge clk);
    transact(p, 6'd5, 1'b0, -1, 1'b1);
    transact(p, 6'd5, 1'b0, -1, 1'b1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
